// File: rtl/i2s_pkg.sv
// Shared I2S constants for the microphone receiver and the live-FFT top.
package i2s_pkg;

  localparam int I2S_SLOT_BITS   = 32;
  localparam int I2S_FRAME_BITS  = 64;
  localparam int MIC_SAMPLE_W    = 24;
  localparam int SAMPLE_RATE_DIV = 512;

  // Frame position counter and slot position widths
  localparam int BIT_IDX_W = $clog2(I2S_FRAME_BITS);
  localparam int POS_W     = $clog2(I2S_SLOT_BITS);

  // clk_25m cycles per bclk half-period that yields SAMPLE_RATE_DIV clocks per frame
  localparam int DEFAULT_CLK_DIV = SAMPLE_RATE_DIV / (2 * I2S_FRAME_BITS);

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } i2s_chan_e;

  // Slot position 0 is the one-bit I2S delay; 1..width carry data MSB-first,
  // everything after is padding.
  function automatic logic slot_bit_captured(input logic [POS_W-1:0] pos,
                                             input int               width);
    return (pos != '0) && (int'(pos) <= width);
  endfunction

endpackage

// File: rtl/i2s_mic_rx_if.sv
// Sample handshake bundle between the I2S receiver and its consumer.
interface i2s_mic_rx_if #(
  parameter int SAMPLE_W = 24
) ();

  logic [SAMPLE_W-1:0] sample;
  logic                sample_valid;
  logic                sample_ready;
  logic                overrun;

  modport master (
    output sample,
    output sample_valid,
    output overrun,
    input  sample_ready
  );

  modport slave (
    input  sample,
    input  sample_valid,
    input  overrun,
    output sample_ready
  );

endinterface

// File: rtl/i2s_clkgen.sv
// Bit clock / word select generator: divides clk_25m into bclk, tracks the
// 64-bit frame position and flags the data sample point.
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic                 clk_25m,
  input  logic                 rst_n,
  output logic                 mic_bclk,
  output logic                 mic_lrclk,
  output logic [BIT_IDX_W-1:0] bit_idx,
  output logic                 sample_pt,
  output logic                 fall_pt
);

  localparam int             DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic                 bclk_q, bclk_d;
  logic                 lrclk_q, lrclk_d;
  logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic                 div_wrap;

  // Next-state for divider, bclk, frame position and word select
  always_comb begin
    div_wrap  = (div_cnt_q == DIV_LAST);
    div_cnt_d = div_wrap ? '0 : div_cnt_q + DIV_W'(1);
    bclk_d    = bclk_q ^ div_wrap;
    // Last cycle of the high phase is both the data sample point and the
    // cycle whose closing edge drops bclk.
    sample_pt = div_wrap & bclk_q;
    fall_pt   = div_wrap & bclk_q;
    bit_idx_d = fall_pt ? bit_idx_q + BIT_IDX_W'(1) : bit_idx_q;
    // Word select follows the frame position so it moves on the bclk fall
    lrclk_d   = bit_idx_d[BIT_IDX_W-1];
  end

  // Clock generator state registers
  always_ff @(posedge clk_25m) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
      lrclk_q   <= 1'b0;
      bit_idx_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
      lrclk_q   <= lrclk_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  assign mic_bclk  = bclk_q;
  assign mic_lrclk = lrclk_q;
  assign bit_idx   = bit_idx_q;

endmodule

// File: rtl/i2s_mic_rx.sv
// I2S master receiver for the MEMS microphone: generates bclk/lrclk,
// deserialises one channel per frame and offers it on a valid/ready port.
module i2s_mic_rx
  import i2s_pkg::*;
#(
  parameter int CLK_DIV  = DEFAULT_CLK_DIV,
  parameter int SAMPLE_W = MIC_SAMPLE_W,
  parameter int CHANNEL  = 0
) (
  input  logic          clk_25m,
  input  logic          rst_n,
  output logic          mic_bclk,
  output logic          mic_lrclk,
  input  logic          mic_data,
  i2s_mic_rx_if.master  smp
);

  localparam logic             CH_BIT  = CHANNEL[0];
  localparam logic [POS_W-1:0] POS_LSB = POS_W'(SAMPLE_W);

  logic [BIT_IDX_W-1:0] bit_idx;
  logic                 sample_pt;
  logic                 fall_pt;

  i2s_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk_25m   (clk_25m),
    .rst_n     (rst_n),
    .mic_bclk  (mic_bclk),
    .mic_lrclk (mic_lrclk),
    .bit_idx   (bit_idx),
    .sample_pt (sample_pt),
    .fall_pt   (fall_pt)
  );

  logic [1:0]          sync_q, sync_d;
  logic [SAMPLE_W-1:0] shift_q, shift_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                valid_q, valid_d;
  logic                overrun_q, overrun_d;

  logic [POS_W-1:0]    pos;
  logic                in_chan;
  logic                capture;
  logic                load;
  logic [SAMPLE_W-1:0] shift_in;

  // Synchroniser, shifter and output handshake next-state
  always_comb begin
    pos      = bit_idx[POS_W-1:0];
    in_chan  = (bit_idx[BIT_IDX_W-1] == CH_BIT);
    sync_d   = {sync_q[0], mic_data};
    shift_in = {shift_q[SAMPLE_W-2:0], sync_q[1]};
    capture  = sample_pt && in_chan && slot_bit_captured(pos, SAMPLE_W);
    load     = capture && (pos == POS_LSB);

    // Start each captured slot from a clean shifter
    shift_d = shift_q;
    if (fall_pt && in_chan && (pos == '0)) begin
      shift_d = '0;
    end else if (capture) begin
      shift_d = shift_in;
    end

    sample_d  = sample_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (load) begin
      // The LSB goes straight into the output word alongside the shift
      sample_d = shift_in;
      valid_d  = 1'b1;
      if (valid_q && !smp.sample_ready) begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && smp.sample_ready) begin
      valid_d = 1'b0;
    end
  end

  // Receiver state registers
  always_ff @(posedge clk_25m) begin
    if (!rst_n) begin
      sync_q    <= '0;
      shift_q   <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      shift_q   <= shift_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign smp.sample       = sample_q;
  assign smp.sample_valid = valid_q;
  assign smp.overrun      = overrun_q;

endmodule

// File: tb/tb_i2s_mic_rx.sv
// Bench for i2s_mic_rx: a mic model driven from the DUT clocks, a scoreboard
// queue of expected left-slot words and a monitor popping on valid&&ready.
module tb_i2s_mic_rx;
  import i2s_pkg::*;

  localparam int SW = 24;

  logic clk_25m = 1'b0;
  logic rst_n   = 1'b0;
  logic mic_data = 1'b0;
  logic mic_bclk;
  logic mic_lrclk;

  i2s_mic_rx_if #(.SAMPLE_W(SW)) smp_if ();

  i2s_mic_rx #(
    .CLK_DIV  (4),
    .SAMPLE_W (SW),
    .CHANNEL  (0)
  ) dut (
    .clk_25m   (clk_25m),
    .rst_n     (rst_n),
    .mic_bclk  (mic_bclk),
    .mic_lrclk (mic_lrclk),
    .mic_data  (mic_data),
    .smp       (smp_if.master)
  );

  always #20 clk_25m = ~clk_25m;

  int errors = 0;
  int checks = 0;

  logic [SW-1:0] exp_q[$];
  logic          mon_en     = 1'b1;
  logic [SW-1:0] left_word  = '0;
  logic [SW-1:0] right_word = '0;
  logic          pad_rand   = 1'b0;

  int   pos       = 0;
  int   hi_cnt    = 0;
  logic prev_bclk = 1'b0;
  logic prev_lr   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Mic model: changes data on each bclk fall, pushes the left word at its LSB
  always @(negedge clk_25m) begin
    if (!rst_n) begin
      pos       = 0;
      hi_cnt    = 0;
      prev_bclk = 1'b0;
      prev_lr   = 1'b0;
    end else begin
      hi_cnt = mic_bclk ? hi_cnt + 1 : 0;
      if (prev_bclk && !mic_bclk) begin
        pos = (mic_lrclk != prev_lr) ? 0 : pos + 1;
        if (pos >= 1 && pos <= SW)
          mic_data = mic_lrclk ? right_word[SW-pos] : left_word[SW-pos];
        else
          mic_data = pad_rand ? 1'($urandom_range(0, 1)) : 1'b0;
        if (!mic_lrclk && pos == SW) exp_q.push_back(left_word);
      end
      prev_bclk = mic_bclk;
      prev_lr   = mic_lrclk;
    end
  end

  // Scoreboard monitor: compare every consumed sample with the queue head
  always @(negedge clk_25m) begin
    if (rst_n && mon_en && smp_if.sample_valid && smp_if.sample_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sample: got %06h, want none queued", smp_if.sample);
      end else begin
        logic [SW-1:0] exp_w;
        exp_w = exp_q.pop_front();
        $display("sample %06h expected %06h", smp_if.sample, exp_w);
        check("sample_data", 32'(smp_if.sample), 32'(exp_w));
      end
    end
  end

  task automatic tick();
    @(negedge clk_25m);
    #1;
  endtask

  task automatic wait_lr(input logic v);
    int n = 0;
    while (mic_lrclk !== v && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL wait_lrclk: got timeout, want lrclk=%0d", v);
    end
  endtask

  // Count clk edges after reset release until sample_valid rises
  task automatic wait_first_valid(input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!smp_if.sample_valid && n < 1000);
    check(name, 32'(n), 32'd200);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_bclk"},    32'(mic_bclk),            32'd0);
    check({tag, "_lrclk"},   32'(mic_lrclk),           32'd0);
    check({tag, "_valid"},   32'(smp_if.sample_valid), 32'd0);
    check({tag, "_overrun"}, 32'(smp_if.overrun),      32'd0);
    check({tag, "_sample"},  32'(smp_if.sample),       32'd0);
  endtask

  initial begin
    int   t;
    int   last_br, b_min, b_max;
    int   last_lr, l_min, l_max;
    int   last_vr, v_min, v_max, v_rises, v_high;
    int   lr_bad, n;
    logic pb, pl, pv;

    smp_if.sample_ready = 1'b1;
    rst_n = 1'b0;
    repeat (4) tick();
    check_reset_state("reset");

    // Test 1: idle line, clock periods and valid cadence
    rst_n = 1'b1;
    wait_first_valid("first_valid_latency");
    t = 200;
    last_br = -1; b_min = 1000000; b_max = 0;
    last_lr = -1; l_min = 1000000; l_max = 0;
    last_vr = 200; v_min = 1000000; v_max = 0; v_rises = 0; v_high = 0;
    lr_bad = 0;
    pb = mic_bclk; pl = mic_lrclk; pv = smp_if.sample_valid;
    repeat (1200) begin
      tick();
      t++;
      if (mic_bclk && !pb) begin
        if (last_br >= 0) begin
          if (t - last_br < b_min) b_min = t - last_br;
          if (t - last_br > b_max) b_max = t - last_br;
        end
        last_br = t;
      end
      if (mic_lrclk != pl && !(pb && !mic_bclk)) lr_bad++;
      if (mic_lrclk && !pl) begin
        if (last_lr >= 0) begin
          if (t - last_lr < l_min) l_min = t - last_lr;
          if (t - last_lr > l_max) l_max = t - last_lr;
        end
        last_lr = t;
      end
      if (smp_if.sample_valid) v_high++;
      if (smp_if.sample_valid && !pv) begin
        v_rises++;
        if (t - last_vr < v_min) v_min = t - last_vr;
        if (t - last_vr > v_max) v_max = t - last_vr;
        last_vr = t;
      end
      pb = mic_bclk; pl = mic_lrclk; pv = smp_if.sample_valid;
    end
    check("bclk_period_min",  32'(b_min), 32'd8);
    check("bclk_period_max",  32'(b_max), 32'd8);
    check("lrclk_period_min", 32'(l_min), 32'd512);
    check("lrclk_period_max", 32'(l_max), 32'd512);
    check("lrclk_not_on_bclk_fall", 32'(lr_bad), 32'd0);
    check("valid_pulse_count", 32'(v_rises), 32'd2);
    check("valid_interval_min", 32'(v_min), 32'd512);
    check("valid_interval_max", 32'(v_max), 32'd512);
    check("valid_pulse_width", 32'(v_high), 32'(v_rises));

    // Test 2: left 100000 captured, right ABCDEF never seen, random padding
    wait_lr(1'b1);
    left_word = 24'h100000;
    right_word = 24'hABCDEF;
    pad_rand = 1'b1;
    repeat (3) begin
      wait_lr(1'b0);
      wait_lr(1'b1);
    end

    // Test 3: alternating extreme words check MSB-first order
    for (int k = 0; k < 4; k++) begin
      left_word = (k % 2 == 0) ? 24'h800001 : 24'h7FFFFF;
      wait_lr(1'b0);
      wait_lr(1'b1);
    end

    // Test 5: ready raised exactly in the load cycle while valid
    mon_en = 1'b0;
    smp_if.sample_ready = 1'b0;
    left_word = 24'h0005A5;
    wait_lr(1'b0);
    wait_lr(1'b1);
    check("hold_valid",   32'(smp_if.sample_valid), 32'd1);
    check("hold_sample",  32'(smp_if.sample),       32'h0005A5);
    check("hold_overrun", 32'(smp_if.overrun),      32'd0);
    left_word = 24'h00BEEF;
    wait_lr(1'b0);
    n = 0;
    while (!(!mic_lrclk && pos == SW && hi_cnt == 4) && n < 600) begin
      tick();
      n++;
    end
    if (n >= 600) begin
      checks++;
      errors++;
      $display("FAIL wait_load_cycle: got timeout, want lsb sample point");
    end
    smp_if.sample_ready = 1'b1;
    tick();
    check("sameload_sample",  32'(smp_if.sample),       32'h00BEEF);
    check("sameload_valid",   32'(smp_if.sample_valid), 32'd1);
    check("sameload_overrun", 32'(smp_if.overrun),      32'd0);
    tick();
    check("sameload_consumed", 32'(smp_if.sample_valid), 32'd0);

    // Test 4: two frames without ready -> overwrite and sticky overrun
    smp_if.sample_ready = 1'b0;
    left_word = 24'h000123;
    wait_lr(1'b1);
    wait_lr(1'b0);
    wait_lr(1'b1);
    check("ovr1_valid",   32'(smp_if.sample_valid), 32'd1);
    check("ovr1_sample",  32'(smp_if.sample),       32'h000123);
    check("ovr1_overrun", 32'(smp_if.overrun),      32'd0);
    left_word = 24'h000456;
    wait_lr(1'b0);
    wait_lr(1'b1);
    check("ovr2_valid",   32'(smp_if.sample_valid), 32'd1);
    check("ovr2_sample",  32'(smp_if.sample),       32'h000456);
    check("ovr2_overrun", 32'(smp_if.overrun),      32'd1);
    smp_if.sample_ready = 1'b1;
    tick();
    check("ovr_drain_valid",   32'(smp_if.sample_valid), 32'd0);
    check("ovr_drain_overrun", 32'(smp_if.overrun),      32'd1);
    check("ovr_drain_sample",  32'(smp_if.sample),       32'h000456);
    exp_q.delete();
    mon_en = 1'b1;

    // Test 6: reset at bit 10 of the left slot
    left_word = 24'h5A5A5A;
    wait_lr(1'b0);
    n = 0;
    while (!(!mic_lrclk && pos == 10) && n < 600) begin
      tick();
      n++;
    end
    if (n >= 600) begin
      checks++;
      errors++;
      $display("FAIL wait_bit10: got timeout, want left slot bit 10");
    end
    rst_n = 1'b0;
    repeat (3) tick();
    check_reset_state("midreset");
    rst_n = 1'b1;
    wait_first_valid("post_reset_latency");
    wait_lr(1'b1);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
